// File: rtl/sha_scan_pkg.sv
// Shared constants, FSM encoding and message-block builders for the nonce scanner.
// Latency: n/a (package).
// Backpressure: n/a (package).
package sha_scan_pkg;

    localparam int HDR_LEN  = 640;
    localparam int DIG_LEN  = 256;
    localparam int BLK_LEN  = 512;
    localparam int NONCE_W  = 32;
    localparam int PFX_LEN  = HDR_LEN - NONCE_W;                    // 608-bit prefix
    localparam int PFX_TAIL = PFX_LEN - BLK_LEN;                    // prefix bits spilling into block 1
    localparam int B1_ZEROS = BLK_LEN - PFX_TAIL - NONCE_W - 1 - 10; // 373
    localparam int H2_ZEROS = BLK_LEN - DIG_LEN - 1 - 9;             // 246

    localparam logic [9:0] HDR_LEN_FIELD = 10'd640;
    localparam logic [8:0] DIG_LEN_FIELD = 9'd256;

    localparam logic [DIG_LEN-1:0] SHA256_IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef enum logic [3:0] {
        IDLE, B0_REQ, B0_WAIT, B1_REQ, B1_WAIT, H2_REQ, H2_WAIT, CHECK, DRAIN
    } scan_state_e;

    // First 512 bits of the padded header; independent of the nonce.
    function automatic logic [BLK_LEN-1:0] blk0_build(input logic [PFX_LEN-1:0] pfx);
        return pfx[PFX_LEN-1 -: BLK_LEN];
    endfunction

    // Tail of the prefix, the nonce, then SHA padding with a 640-bit length.
    function automatic logic [BLK_LEN-1:0] blk1_build(input logic [PFX_TAIL-1:0] tail,
                                                      input logic [NONCE_W-1:0]  nonce);
        return {tail, nonce, 1'b1, {B1_ZEROS{1'b0}}, HDR_LEN_FIELD};
    endfunction

    // Single block for hashing the first digest again (256-bit message).
    function automatic logic [BLK_LEN-1:0] h2_build(input logic [DIG_LEN-1:0] h1);
        return {h1, 1'b1, {H2_ZEROS{1'b0}}, DIG_LEN_FIELD};
    endfunction

endpackage

// File: rtl/nonce_range_ctr.sv
// Holds the in-flight nonce and the inclusive end of the scan range.
// Latency: load/increment visible one cycle later; is_last is combinational on state.
// Backpressure: none; the controller decides when to load or step.
module nonce_range_ctr (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        inc_i,
    input  logic [31:0] start_i,
    input  logic [31:0] end_i,
    output logic [31:0] nonce_o,
    output logic        is_last_o
);

    logic [31:0] nonce_q, nonce_d;
    logic [31:0] end_q, end_d;

    // Load both bounds at scan start; stepping wraps naturally at 2^32.
    always_comb begin
        nonce_d = nonce_q;
        end_d   = end_q;
        if (load_i) begin
            nonce_d = start_i;
            end_d   = end_i;
        end else if (inc_i) begin
            nonce_d = nonce_q + 32'd1;
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nonce_q <= '0;
            end_q   <= '0;
        end else begin
            nonce_q <= nonce_d;
            end_q   <= end_d;
        end
    end

    // Equality rather than a magnitude test keeps wrapped ranges correct.
    assign is_last_o = (nonce_q == end_q);
    assign nonce_o   = nonce_q;

endmodule

// File: rtl/nonce_scan_ctrl.sv
// Runs a double-SHA-256 nonce scan: block 0 once, then block 1 + rehash per nonce, target compare.
// Latency: per nonce two core round-trips plus one CHECK cycle; block offers registered.
// Backpressure: block offer held stable until blk_ready; digests always accepted.
module nonce_scan_ctrl
    import sha_scan_pkg::*;
#(
    parameter bit STOP_ON_FIND = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [607:0] header_prefix,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic [255:0] target,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic [255:0] blk_iv,
    input  logic         dig_valid,
    input  logic [255:0] dig_data,
    output logic         busy,
    output logic [31:0]  cur_nonce,
    output logic         found,
    output logic [31:0]  found_nonce,
    output logic [255:0] found_hash,
    output logic         done
);

    scan_state_e          state_q, state_d;
    logic                 blk_valid_q, blk_valid_d;
    logic [BLK_LEN-1:0]   blk_data_q, blk_data_d;
    logic [DIG_LEN-1:0]   blk_iv_q, blk_iv_d;
    logic [DIG_LEN-1:0]   mid_q, mid_d;
    logic [DIG_LEN-1:0]   h2_q, h2_d;
    logic [PFX_TAIL-1:0]  tail_q, tail_d;
    logic [DIG_LEN-1:0]   target_q, target_d;
    logic                 busy_q, busy_d;
    logic                 found_q, found_d;
    logic                 done_q, done_d;
    logic [31:0]          found_nonce_q, found_nonce_d;
    logic [DIG_LEN-1:0]   found_hash_q, found_hash_d;
    logic                 ctr_load, ctr_inc, is_last;
    logic                 xfer, hit;

    nonce_range_ctr u_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (ctr_load),
        .inc_i    (ctr_inc),
        .start_i  (nonce_start),
        .end_i    (nonce_end),
        .nonce_o  (cur_nonce),
        .is_last_o(is_last)
    );

    assign xfer = blk_valid_q && blk_ready;
    assign hit  = (h2_q < target_q);

    // Next-state, block offers and hit reporting.
    always_comb begin
        state_d       = state_q;
        blk_valid_d   = blk_valid_q;
        blk_data_d    = blk_data_q;
        blk_iv_d      = blk_iv_q;
        mid_d         = mid_q;
        h2_d          = h2_q;
        tail_d        = tail_q;
        target_d      = target_q;
        found_d       = 1'b0;
        done_d        = 1'b0;
        found_nonce_d = found_nonce_q;
        found_hash_d  = found_hash_q;
        ctr_load      = 1'b0;
        ctr_inc       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    tail_d      = header_prefix[PFX_TAIL-1:0];
                    target_d    = target;
                    ctr_load    = 1'b1;
                    blk_valid_d = 1'b1;
                    blk_data_d  = blk0_build(header_prefix);
                    blk_iv_d    = SHA256_IV;
                    state_d     = B0_REQ;
                end
            end
            B0_REQ, B1_REQ, H2_REQ: begin
                if (xfer || abort) blk_valid_d = 1'b0;
                // An abort racing an accepted block still leaves a digest to swallow.
                if (abort)                   state_d = xfer ? DRAIN : IDLE;
                else if (xfer && state_q == B0_REQ) state_d = B0_WAIT;
                else if (xfer && state_q == B1_REQ) state_d = B1_WAIT;
                else if (xfer)               state_d = H2_WAIT;
            end
            B0_WAIT: begin
                if (abort) begin
                    state_d = dig_valid ? IDLE : DRAIN;
                end else if (dig_valid) begin
                    mid_d       = dig_data;
                    blk_valid_d = 1'b1;
                    blk_data_d  = blk1_build(tail_q, cur_nonce);
                    blk_iv_d    = dig_data;
                    state_d     = B1_REQ;
                end
            end
            B1_WAIT: begin
                if (abort) begin
                    state_d = dig_valid ? IDLE : DRAIN;
                end else if (dig_valid) begin
                    // h1 lives on in blk_data for the rehash offer.
                    blk_valid_d = 1'b1;
                    blk_data_d  = h2_build(dig_data);
                    blk_iv_d    = SHA256_IV;
                    state_d     = H2_REQ;
                end
            end
            H2_WAIT: begin
                if (abort) begin
                    state_d = dig_valid ? IDLE : DRAIN;
                end else if (dig_valid) begin
                    h2_d    = dig_data;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (hit) begin
                    found_d       = 1'b1;
                    found_nonce_d = cur_nonce;
                    found_hash_d  = h2_q;
                end
                if (abort) begin
                    state_d = IDLE;
                end else if ((hit && STOP_ON_FIND) || is_last) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    ctr_inc     = 1'b1;
                    blk_valid_d = 1'b1;
                    blk_data_d  = blk1_build(tail_q, cur_nonce + 32'd1);
                    blk_iv_d    = mid_q;
                    state_d     = B1_REQ;
                end
            end
            DRAIN: begin
                if (dig_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // All controller state; async reset returns everything to zero/IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            blk_valid_q   <= 1'b0;
            blk_data_q    <= '0;
            blk_iv_q      <= '0;
            mid_q         <= '0;
            h2_q          <= '0;
            tail_q        <= '0;
            target_q      <= '0;
            busy_q        <= 1'b0;
            found_q       <= 1'b0;
            done_q        <= 1'b0;
            found_nonce_q <= '0;
            found_hash_q  <= '0;
        end else begin
            state_q       <= state_d;
            blk_valid_q   <= blk_valid_d;
            blk_data_q    <= blk_data_d;
            blk_iv_q      <= blk_iv_d;
            mid_q         <= mid_d;
            h2_q          <= h2_d;
            tail_q        <= tail_d;
            target_q      <= target_d;
            busy_q        <= busy_d;
            found_q       <= found_d;
            done_q        <= done_d;
            found_nonce_q <= found_nonce_d;
            found_hash_q  <= found_hash_d;
        end
    end

    assign blk_valid   = blk_valid_q;
    assign blk_data    = blk_data_q;
    assign blk_iv      = blk_iv_q;
    assign busy        = busy_q;
    assign found       = found_q;
    assign done        = done_q;
    assign found_nonce = found_nonce_q;
    assign found_hash  = found_hash_q;

endmodule

// File: tb/tb_nonce_scan_ctrl.sv
// Scoreboarded bench for nonce_scan_ctrl with a toy compression core.
// Latency: core returns a digest a programmable number of cycles after acceptance.
// Backpressure: blk_ready can be stalled for a chosen offer.
module tb_nonce_scan_ctrl;

    localparam logic [255:0] IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef struct { logic [511:0] dat; logic [255:0] iv; } blk_exp_t;
    typedef struct { logic [31:0] nonce; logic [255:0] hash; logic with_done; } fnd_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         start = 1'b0, abort = 1'b0, sel = 1'b0;
    logic [607:0] header_prefix = '0;
    logic [31:0]  nonce_start = '0, nonce_end = '0;
    logic [255:0] target = '0;
    logic         blk_ready = 1'b1, dig_valid = 1'b0;
    logic [255:0] dig_data = '0;

    logic a_start, a_abort, a_rdy, b_start, b_abort, b_rdy;
    logic a_blk_valid, a_busy, a_found, a_done, b_blk_valid, b_busy, b_found, b_done;
    logic [511:0] a_blk_data, b_blk_data;
    logic [255:0] a_blk_iv, b_blk_iv, a_found_hash, b_found_hash;
    logic [31:0]  a_cur_nonce, b_cur_nonce, a_found_nonce, b_found_nonce;
    logic m_blk_valid, m_busy, m_found, m_done;
    logic [511:0] m_blk_data;
    logic [255:0] m_blk_iv, m_found_hash;
    logic [31:0]  m_cur_nonce, m_found_nonce;

    assign a_start = start & ~sel;  assign b_start = start & sel;
    assign a_abort = abort & ~sel;  assign b_abort = abort & sel;
    assign a_rdy   = blk_ready & ~sel; assign b_rdy = blk_ready & sel;
    assign m_blk_valid   = sel ? b_blk_valid   : a_blk_valid;
    assign m_busy        = sel ? b_busy        : a_busy;
    assign m_found       = sel ? b_found       : a_found;
    assign m_done        = sel ? b_done        : a_done;
    assign m_blk_data    = sel ? b_blk_data    : a_blk_data;
    assign m_blk_iv      = sel ? b_blk_iv      : a_blk_iv;
    assign m_found_hash  = sel ? b_found_hash  : a_found_hash;
    assign m_cur_nonce   = sel ? b_cur_nonce   : a_cur_nonce;
    assign m_found_nonce = sel ? b_found_nonce : a_found_nonce;

    nonce_scan_ctrl #(.STOP_ON_FIND(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort),
        .header_prefix(header_prefix), .nonce_start(nonce_start), .nonce_end(nonce_end),
        .target(target), .blk_valid(a_blk_valid), .blk_ready(a_rdy), .blk_data(a_blk_data),
        .blk_iv(a_blk_iv), .dig_valid(dig_valid), .dig_data(dig_data), .busy(a_busy),
        .cur_nonce(a_cur_nonce), .found(a_found), .found_nonce(a_found_nonce),
        .found_hash(a_found_hash), .done(a_done));

    nonce_scan_ctrl #(.STOP_ON_FIND(1'b0)) dut_nc (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
        .header_prefix(header_prefix), .nonce_start(nonce_start), .nonce_end(nonce_end),
        .target(target), .blk_valid(b_blk_valid), .blk_ready(b_rdy), .blk_data(b_blk_data),
        .blk_iv(b_blk_iv), .dig_valid(dig_valid), .dig_data(dig_data), .busy(b_busy),
        .cur_nonce(b_cur_nonce), .found(b_found), .found_nonce(b_found_nonce),
        .found_hash(b_found_hash), .done(b_done));

    int n_chk = 0, n_err = 0;
    blk_exp_t blk_q[$];
    fnd_exp_t fnd_q[$];
    int       done_q[$];

    int xfer_cnt = 0, core_lat = 3, dig_cnt = 0;
    bit dig_pend = 1'b0;
    logic [255:0] dig_next = '0;
    int stall_idx = -1, stall_left = 0;
    bit stall_started = 1'b0;
    logic [511:0] stall_dat;
    logic [255:0] stall_iv;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Toy compression function: cheap, but depends on every block and iv bit.
    function automatic logic [255:0] core_f(input logic [255:0] iv, input logic [511:0] blk);
        return iv ^ blk[511:256] ^ {blk[254:0], blk[255]};
    endfunction

    function automatic logic [255:0] model_h2(input logic [607:0] hdr, input logic [31:0] n);
        logic [1023:0] msg;
        logic [255:0] mid, h1;
        msg = {hdr, n, 1'b1, 373'b0, 10'h280};
        mid = core_f(IV, msg[1023:512]);
        h1  = core_f(mid, msg[511:0]);
        return core_f(IV, {h1, 1'b1, 246'b0, 9'h100});
    endfunction

    task automatic build_expect(input logic [607:0] hdr, input logic [31:0] s, input logic [31:0] e,
                                input logic [255:0] tgt, input bit stop);
        logic [1023:0] msg;
        logic [511:0]  b2;
        logic [255:0]  mid, h1, h2;
        logic [31:0]   n;
        int nx;
        bit hit, last;
        msg = {hdr, s, 1'b1, 373'b0, 10'h280};
        blk_q.push_back('{msg[1023:512], IV});
        mid = core_f(IV, msg[1023:512]);
        nx = 1;
        n = s;
        for (int k = 0; k < 64; k++) begin
            msg = {hdr, n, 1'b1, 373'b0, 10'h280};
            blk_q.push_back('{msg[511:0], mid});
            h1 = core_f(mid, msg[511:0]);
            b2 = {h1, 1'b1, 246'b0, 9'h100};
            blk_q.push_back('{b2, IV});
            h2 = core_f(IV, b2);
            nx += 2;
            hit  = (h2 < tgt);
            last = (n == e);
            if (hit) fnd_q.push_back('{n, h2, stop || last});
            if ((hit && stop) || last) begin
                done_q.push_back(nx);
                break;
            end
            n = n + 32'd1;
        end
    endtask

    // Core model plus output monitor; everything decided on the falling edge.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            dig_valid = 1'b0;
            dig_pend  = 1'b0;
            blk_ready = 1'b1;
        end else begin
            dig_valid = 1'b0;
            if (dig_pend) begin
                dig_cnt--;
                if (dig_cnt <= 0) begin
                    dig_valid = 1'b1;
                    dig_data  = dig_next;
                    dig_pend  = 1'b0;
                end
            end
            if (m_found) begin
                if (fnd_q.size() == 0) chk("found_unexpected", 1, 0);
                else begin
                    fnd_exp_t f;
                    f = fnd_q.pop_front();
                    chk("found_nonce", m_found_nonce, f.nonce);
                    chk("found_hash", m_found_hash, f.hash);
                    chk("found_with_done", m_done, f.with_done);
                end
            end
            if (m_done) begin
                if (done_q.size() == 0) chk("done_unexpected", 1, 0);
                else chk("done_xfers", xfer_cnt, done_q.pop_front());
            end
            blk_ready = 1'b1;
            if (stall_left > 0 && xfer_cnt == stall_idx && (stall_started || m_blk_valid)) begin
                if (!stall_started) begin
                    stall_started = 1'b1;
                    stall_dat = m_blk_data;
                    stall_iv  = m_blk_iv;
                end else begin
                    chk("stall_valid", m_blk_valid, 1);
                    chk("stall_data", m_blk_data, stall_dat);
                    chk("stall_iv", m_blk_iv, stall_iv);
                end
                stall_left--;
                blk_ready = 1'b0;
            end
            if (m_blk_valid && blk_ready) begin
                if (blk_q.size() == 0) chk("xfer_unexpected", 1, 0);
                else begin
                    blk_exp_t b;
                    b = blk_q.pop_front();
                    chk("blk_data", m_blk_data, b.dat);
                    chk("blk_iv", m_blk_iv, b.iv);
                end
                xfer_cnt++;
                dig_next = core_f(m_blk_iv, m_blk_data);
                dig_pend = 1'b1;
                dig_cnt  = core_lat;
            end
        end
    end

    task automatic check_drained(input string tag);
        chk({tag, "_blk_left"}, blk_q.size(), 0);
        chk({tag, "_fnd_left"}, fnd_q.size(), 0);
        chk({tag, "_done_left"}, done_q.size(), 0);
    endtask

    task automatic run_scan(input logic [607:0] hdr, input logic [31:0] s, input logic [31:0] e,
                            input logic [255:0] tgt, input bit use_nc, input string tag);
        bit ok;
        @(negedge clk);
        sel = use_nc;
        header_prefix = hdr; nonce_start = s; nonce_end = e; target = tgt;
        xfer_cnt = 0;
        build_expect(hdr, s, e, tgt, !use_nc);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (!m_busy) begin ok = 1'b1; break; end
        end
        chk({tag, "_finished"}, ok, 1);
        check_drained(tag);
    endtask

    task automatic wait_xfers(input int n, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (xfer_cnt == n) begin ok = 1'b1; break; end
        end
        chk({tag, "_reached"}, ok, 1);
    endtask

    initial begin
        logic [607:0] hdr, hdr3;
        logic [255:0] tgt3, h2hit;
        logic [1023:0] msg;
        bit got, ok;
        int cnt;

        for (int w = 0; w < 19; w++) hdr[w*32 +: 32] = $urandom;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", a_busy, 0);
        chk("rst_blk_valid", a_blk_valid, 0);
        chk("rst_found", a_found, 0);
        chk("rst_done", a_done, 0);
        chk("rst_blk_data", a_blk_data, 0);
        chk("rst_blk_iv", a_blk_iv, 0);
        chk("rst_cur_nonce", a_cur_nonce, 0);
        chk("rst_found_nonce", a_found_nonce, 0);
        chk("rst_found_hash", a_found_hash, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single nonce, everything hits: found and done together.
        run_scan(hdr, 32'h5, 32'h5, {256{1'b1}}, 1'b0, "t1");
        chk("t1_xfers", xfer_cnt, 3);
        chk("t1_found_nonce", m_found_nonce, 32'h5);
        chk("t1_busy_low", m_busy, 0);

        // Wrapping range, nothing hits.
        run_scan(hdr, 32'hFFFF_FFFE, 32'h0000_0001, '0, 1'b0, "t2");
        chk("t2_xfers", xfer_cnt, 9);
        chk("t2_found_held", m_found_nonce, 32'h5);

        // Search for a header where only 0x7C2BAC1D in the range beats target.
        got = 1'b0;
        for (int t = 0; t < 5000 && !got; t++) begin
            for (int w = 0; w < 19; w++) hdr3[w*32 +: 32] = $urandom;
            h2hit = model_h2(hdr3, 32'h7C2B_AC1D);
            tgt3  = h2hit + 256'd1;
            cnt = 0;
            for (int n = 0; n < 5; n++)
                if (model_h2(hdr3, 32'h7C2B_AC1B + n) < tgt3) cnt++;
            if (cnt == 1 && tgt3 != '0) got = 1'b1;
        end
        chk("t3_model_header", got, 1);
        run_scan(hdr3, 32'h7C2B_AC1B, 32'h7C2B_AC1F, tgt3, 1'b0, "t3stop");
        chk("t3stop_xfers", xfer_cnt, 7);
        chk("t3stop_found_nonce", m_found_nonce, 32'h7C2B_AC1D);
        chk("t3stop_found_hash", m_found_hash, h2hit);
        run_scan(hdr3, 32'h7C2B_AC1B, 32'h7C2B_AC1F, tgt3, 1'b1, "t3cont");
        chk("t3cont_xfers", xfer_cnt, 11);
        chk("t3cont_found_nonce", m_found_nonce, 32'h7C2B_AC1D);
        chk("t3cont_found_hash", m_found_hash, h2hit);

        // Stall the first block-1 offer for seven cycles.
        stall_idx = 1; stall_left = 7; stall_started = 1'b0;
        run_scan(hdr, 32'h40, 32'h40, '0, 1'b0, "t4");
        chk("t4_stall_done", stall_left, 0);
        chk("t4_xfers", xfer_cnt, 3);
        stall_idx = -1;

        // Abort while block 1 is in the core; digest arrives five cycles later.
        @(negedge clk);
        sel = 1'b0;
        core_lat = 5;
        xfer_cnt = 0;
        nonce_start = 32'h100; nonce_end = 32'h200; target = {256{1'b1}};
        header_prefix = hdr;
        msg = {hdr, 32'h100, 1'b1, 373'b0, 10'h280};
        blk_q.push_back('{msg[1023:512], IV});
        blk_q.push_back('{msg[511:0], core_f(IV, msg[1023:512])});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_xfers(2, "t5");
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (dig_valid) begin ok = 1'b1; break; end
            chk("t5_busy_draining", m_busy, 1);
            @(negedge clk);
        end
        chk("t5_dig_seen", ok, 1);
        chk("t5_busy_at_dig", m_busy, 1);
        @(negedge clk);
        #1;
        chk("t5_busy_after", m_busy, 0);
        check_drained("t5");
        core_lat = 3;
        run_scan(hdr, 32'h10, 32'h10, {256{1'b1}}, 1'b0, "t5clean");
        chk("t5clean_found_nonce", m_found_nonce, 32'h10);

        // Async reset while the rehash digest is pending.
        @(negedge clk);
        xfer_cnt = 0;
        nonce_start = 32'h20; nonce_end = 32'h22; target = '0;
        build_expect(hdr, 32'h20, 32'h22, '0, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_xfers(3, "t6");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", m_busy, 0);
        chk("t6_blk_valid", m_blk_valid, 0);
        chk("t6_blk_data", m_blk_data, 0);
        chk("t6_blk_iv", m_blk_iv, 0);
        chk("t6_cur_nonce", m_cur_nonce, 0);
        chk("t6_found_nonce", m_found_nonce, 0);
        chk("t6_found_hash", m_found_hash, 0);
        blk_q.delete(); fnd_q.delete(); done_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_scan(hdr3, 32'h30, 32'h30, {256{1'b1}}, 1'b0, "t6rescan");
        chk("t6rescan_xfers", xfer_cnt, 3);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/nonce_scan_ctrl.md
Name: nonce_scan_ctrl

Overview:
- Sequences a full double-SHA-256 nonce scan over one 640-bit block header.
- Builds the padded message blocks and issues them over a valid/ready interface to an external single-block SHA-256 compression core.
- Compares each final hash against a target and reports hits.
- Sits between host/config registers and the compression core. It replaces the free-running padding register with a scheduled, handshaked flow.

Parameters:
STOP_ON_FIND, 1, 1: halt the scan at the first hit; 0: pulse found and continue to nonce_end

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin scan; sampled only in IDLE
abort  in  1  cancel scan; sampled in any non-IDLE state
header_prefix  in  608  header without nonce; latched at start
nonce_start  in  32  first nonce, inclusive; latched at start
nonce_end  in  32  last nonce, inclusive; latched at start
target  in  256  hit when hash < target (unsigned); latched at start
blk_valid  out  1  block offer to core
blk_ready  in  1  core accepts block
blk_data  out  512  message block
blk_iv  out  256  chaining input for this block
dig_valid  in  1  one-cycle digest-return pulse
dig_data  in  256  compression output
busy  out  1  high from the start cycle until return to IDLE
cur_nonce  out  32  nonce currently in flight
found  out  1  one-cycle hit pulse
found_nonce  out  32  last hit nonce; held until next hit or reset
found_hash  out  256  last hit hash; held until next hit or reset
done  out  1  one-cycle pulse when range exhausted or stopped on hit

Behaviour:
- Reset: FSM to IDLE. busy, blk_valid, found and done are 0. blk_data, blk_iv, cur_nonce, found_nonce and found_hash are 0. The midstate register is 0.
- Message layout, MSB-first:
  - msg[1023:0] = {header_prefix, nonce, 1'b1, 373'b0, 10'h280}, giving length 640 in msg[9:0].
  - Block 0 = msg[1023:512]; it is nonce-independent. Block 1 = msg[511:0]; the nonce is in msg[415:384].
- Second-hash block: {h1, 1'b1, 246'b0, 9'h100}, i.e. length 256. No byte swapping anywhere; the host owns endianness.
- FSM states: IDLE, B0_REQ, B0_WAIT, B1_REQ, B1_WAIT, H2_REQ, H2_WAIT, CHECK, DRAIN.
  - IDLE: on start (abort low), latch inputs, set cur_nonce = nonce_start, busy = 1, go to B0_REQ.
  - B0_REQ: blk_data = block 0, blk_iv = SHA256_IV. On transfer, go to B0_WAIT.
  - B0_WAIT: on dig_valid, store dig_data as midstate, go to B1_REQ. Block 0 is compressed once per scan.
  - B1_REQ: blk_data = block 1 for cur_nonce, blk_iv = midstate. On transfer, go to B1_WAIT.
  - B1_WAIT: on dig_valid, latch h1, go to H2_REQ.
  - H2_REQ: blk_data = second-hash block, blk_iv = SHA256_IV. On transfer, go to H2_WAIT.
  - H2_WAIT: on dig_valid, latch h2, go to CHECK.
  - CHECK (1 cycle):
    - If h2 < target: pulse found and update found_nonce/found_hash.
    - If the hit occurred and STOP_ON_FIND = 1, or cur_nonce == nonce_end: pulse done, clear busy, go to IDLE.
    - Otherwise cur_nonce <= cur_nonce + 1 (mod 2^32) and go to B1_REQ.
- Handshake rules:
  - A transfer occurs when blk_valid && blk_ready on a clock edge.
  - blk_valid is registered. blk_data and blk_iv stay stable while blk_valid is high and not accepted.
  - blk_valid drops the cycle after a transfer. At most one block is outstanding.
  - Controller is always ready for a digest. dig_valid outside the *_WAIT/DRAIN states is ignored.
- Nonce range:
  - Inclusive. nonce_end < nonce_start wraps through 0xFFFFFFFF to 0.
  - start == end scans exactly one nonce.
  - end == start-1 scans all 2^32 nonces.
- Latency: each nonce costs 2 block transfers plus 1 CHECK cycle, beyond the core's latency.
- Abort:
  - In *_REQ before a transfer: drop blk_valid, go to IDLE next cycle.
  - In *_WAIT: go to DRAIN, discard the pending dig_valid, then go to IDLE.
  - In CHECK: finish the found update this cycle, then go to IDLE.
  - No done pulse on abort. busy falls on entry to IDLE.
- Simultaneous events:
  - start and abort together in IDLE: no scan starts.
  - start while busy: ignored.
  - A hit on the last nonce produces found and done in the same cycle.
- Async reset mid-scan: immediate return to reset values. The core is assumed reset by the same rst_n.

Decomposition:
- Package sha_scan_pkg holds:
  - SHA256_IV (256-bit constant)
  - HDR_LEN = 640 and DIG_LEN = 256
  - Padding/length field constants
  - The FSM state enum
- One natural sub-module: nonce_range_ctr. It holds cur_nonce, handles load/increment, and provides a wrap-safe is_last = (cur_nonce == nonce_end).

Test Plan:
- target = all-ones, nonce_start = nonce_end = 0x00000005 -> exactly 3 block transfers, found_nonce = 0x5, found and done in the same cycle, busy low after.
- target = 0, nonce_start = 0xFFFFFFFE, nonce_end = 0x00000001 -> blk_data nonce field sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001; 9 transfers; done, no found.
- Reference model picks target so only nonce 0x7C2BAC1D hits, range 0x7C2BAC1B..0x7C2BAC1F, STOP_ON_FIND = 1 -> found_nonce = 0x7C2BAC1D, found_hash matches the model, done after 3 nonces. With STOP_ON_FIND = 0 -> same single found, done after 5 nonces.
- blk_ready held low for 7 cycles in B1_REQ -> blk_valid, blk_data and blk_iv stable throughout; exactly one transfer.
- abort in B1_WAIT with the core returning its digest 5 cycles later -> busy stays high until that dig_valid, then IDLE; no found or done; a following start runs cleanly.
- rst_n asserted mid H2_WAIT -> all outputs at reset values immediately; a new start rescans block 0 with SHA256_IV.
